gnn_out_collector: RTL and testbench
====================================

GNN_OUT_COLLECTOR -- requirements
Module: gnn_out_collector

Interface
REQ-001 Parameter NUM_NODES, default 4, number of graph nodes collected per inference.
REQ-002 Parameter DATA_W, default 21, width of each GNN output score.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_ready  input  1  inference-start strobe, the same signal that launches the GNN.
REQ-006 outK_nodeN  input  DATA_W  GNN output K (0..1) of node N (0..NUM_NODES-1), signed two's complement.
REQ-007 out1K_ready_nodeN  input  1  valid flag for outK_nodeN; level, may stay high.
REQ-008 res_valid  output  1  result record valid.
REQ-009 res_ready  input  1  downstream accepts record.
REQ-010 res_node  output  2  node index of record.
REQ-011 res_class  output  1  winning output index.
REQ-012 res_score  output  DATA_W  winning score, signed.
REQ-013 busy  output  1  high in CAPTURE or EMIT.
REQ-014 done  output  1  one-cycle pulse after last record accepted.

Function
REQ-015 FSM states IDLE, CAPTURE, EMIT, and DONE; reset state IDLE.
REQ-016 IDLE: in_ready=1 -> CAPTURE next cycle; all 8 capture flags cleared on that transition.
REQ-017 CAPTURE: each cycle, for every flag still clear whose ready input is 1, register the matching outK_nodeN and set the flag.
REQ-018 CAPTURE: inputs for already-set flags are ignored; later changes on captured data have no effect.
REQ-019 CAPTURE -> EMIT on the cycle after all 8 flags are set; if all 8 ready inputs are high on CAPTURE entry, capture happens in that first cycle.
REQ-020 In CAPTURE or EMIT, in_ready is ignored; there is no restart mid-operation.
REQ-021 EMIT: records are presented for node 0, 1, 2, 3 in order; res_valid=1 throughout EMIT.
REQ-022 Record: res_class=1 iff signed out1 > signed out0, else 0 (tie -> 0); res_score is the selected value.
REQ-023 Record fields are stable while res_valid=1 and res_ready=0; transfer occurs when res_valid and res_ready are both 1.
REQ-024 On transfer, advance to the next node in the same state; on transfer of node NUM_NODES-1 -> DONE.
REQ-025 Records are back-to-back with res_ready held high: one record per cycle, no bubbles.
REQ-026 DONE: done=1, res_valid=0 for one cycle; then IDLE. in_ready in DONE is ignored.
REQ-027 Latency: first res_valid occurs 1 cycle after the 8th flag is captured.
REQ-028 Comparison is full DATA_W signed; no truncation or saturation.

Reset
REQ-029 rst=1 forces, asynchronously: state=IDLE, flags=0, node index=0, captured data=0.
REQ-030 Outputs under reset: res_valid=0, res_node=0, res_class=0, res_score=0, busy=0, done=0.
REQ-031 Reset asserted mid-CAPTURE or mid-EMIT aborts; no record or done is emitted for the aborted inference.

Structure
REQ-032 Shared package gnn_pkg holds NUM_NODES, DATA_W, and the collector state enum type.
REQ-033 One sub-module gnn_argmax2 holds the combinational signed 2-input compare; it outputs class and score.
REQ-034 Captured scores are stored as a NUM_NODES x 2 register array indexed by node and output.

Verification
REQ-035 All 8 ready inputs high with node0 (out0, out1) = (5, 9) -> node0 record class=1, score=9; 4 records on 4 consecutive cycles; then done pulse.
REQ-036 Ready flags staggered over 6 cycles; data changed after each capture -> records use the first-captured values only.
REQ-037 node2 (out0, out1) = (-3, -3) -> class=0, score=-3; node3 (out0, out1) = (-1048576, 1) -> class=1, score=1.
REQ-038 res_ready low for 3 cycles on node1 -> res_node=1 and record fields held stable; no node skipped.
REQ-039 rst pulsed during EMIT after node1 is accepted -> res_valid=0 immediately; no done; the next in_ready starts a fresh inference.
REQ-040 in_ready pulsed during CAPTURE -> no effect; flags not cleared.

Source files
------------

// File: rtl/gnn_pkg.sv
// Shared constants and the state type for the GNN output collector.
package gnn_pkg;
  localparam int NUM_NODES = 4;
  localparam int DATA_W    = 21;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_EMIT    = 2'd2,
    ST_DONE    = 2'd3
  } coll_state_t;
endpackage

// File: rtl/gnn_argmax2.sv
// Signed two-way argmax; a tie keeps output 0.
module gnn_argmax2 #(
  parameter int DATA_W = 21
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     cls,
  output logic signed [DATA_W-1:0] score
);
  assign cls   = (b > a);
  assign score = cls ? b : a;
endmodule

// File: rtl/gnn_out_collector.sv
// Captures the two GNN outputs of every node as their ready flags arrive,
// then streams one argmax record per node over a valid/ready handshake.
module gnn_out_collector
  import gnn_pkg::*;
#(
  parameter int NUM_NODES = gnn_pkg::NUM_NODES,
  parameter int DATA_W    = gnn_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_ready,
  input  logic signed [DATA_W-1:0] out0_node0,
  input  logic signed [DATA_W-1:0] out1_node0,
  input  logic signed [DATA_W-1:0] out0_node1,
  input  logic signed [DATA_W-1:0] out1_node1,
  input  logic signed [DATA_W-1:0] out0_node2,
  input  logic signed [DATA_W-1:0] out1_node2,
  input  logic signed [DATA_W-1:0] out0_node3,
  input  logic signed [DATA_W-1:0] out1_node3,
  input  logic                     out10_ready_node0,
  input  logic                     out11_ready_node0,
  input  logic                     out10_ready_node1,
  input  logic                     out11_ready_node1,
  input  logic                     out10_ready_node2,
  input  logic                     out11_ready_node2,
  input  logic                     out10_ready_node3,
  input  logic                     out11_ready_node3,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [1:0]               res_node,
  output logic                     res_class,
  output logic signed [DATA_W-1:0] res_score,
  output logic                     busy,
  output logic                     done
);
  localparam logic [1:0] LAST_NODE = 2'(NUM_NODES - 1);

  coll_state_t state, state_nx;

  logic signed [DATA_W-1:0] din      [NUM_NODES][2];
  logic signed [DATA_W-1:0] score_p0 [NUM_NODES][2];
  logic [NUM_NODES-1:0][1:0] rdy;
  logic [NUM_NODES-1:0][1:0] flag_p0;
  logic [1:0]                node_q;
  logic                      all_flags;
  logic                      xfer;
  logic                      sel_cls;
  logic signed [DATA_W-1:0]  sel_score;

  assign din[0][0] = out0_node0;
  assign din[0][1] = out1_node0;
  assign din[1][0] = out0_node1;
  assign din[1][1] = out1_node1;
  assign din[2][0] = out0_node2;
  assign din[2][1] = out1_node2;
  assign din[3][0] = out0_node3;
  assign din[3][1] = out1_node3;

  assign rdy[0] = {out11_ready_node0, out10_ready_node0};
  assign rdy[1] = {out11_ready_node1, out10_ready_node1};
  assign rdy[2] = {out11_ready_node2, out10_ready_node2};
  assign rdy[3] = {out11_ready_node3, out10_ready_node3};

  assign all_flags = &flag_p0;
  assign xfer      = res_valid && res_ready;

  // Capture stage: each score is latched once, on the first cycle its flag is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      flag_p0 <= '0;
      node_q  <= '0;
      for (int n = 0; n < NUM_NODES; n++)
        for (int k = 0; k < 2; k++)
          score_p0[n][k] <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && in_ready) begin
        flag_p0 <= '0;
      end else if (state == ST_CAPTURE) begin
        for (int n = 0; n < NUM_NODES; n++)
          for (int k = 0; k < 2; k++)
            if (!flag_p0[n][k] && rdy[n][k]) begin
              score_p0[n][k] <= din[n][k];
              flag_p0[n][k]  <= 1'b1;
            end
      end
      if (state == ST_EMIT && xfer)
        node_q <= (node_q == LAST_NODE) ? 2'd0 : node_q + 2'd1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:    if (in_ready) state_nx = ST_CAPTURE;
      ST_CAPTURE: if (all_flags) state_nx = ST_EMIT;
      ST_EMIT:    if (xfer && node_q == LAST_NODE) state_nx = ST_DONE;
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  gnn_argmax2 #(.DATA_W(DATA_W)) u_argmax (
    .a     (score_p0[node_q][0]),
    .b     (score_p0[node_q][1]),
    .cls   (sel_cls),
    .score (sel_score)
  );

  // Emit stage: record fields are forced to zero whenever no record is offered.
  assign res_valid = (state == ST_EMIT);
  assign res_node  = node_q;
  assign res_class = res_valid && sel_cls;
  assign res_score = res_valid ? sel_score : '0;
  assign busy      = (state == ST_CAPTURE) || (state == ST_EMIT);
  assign done      = (state == ST_DONE);
endmodule

// File: tb/tb_gnn_out_collector.sv
// Scoreboard bench for gnn_out_collector: expected records queued at stimulus time.
module tb_gnn_out_collector;
  localparam int DW = 21;

  typedef struct {
    logic [1:0]           node;
    logic                 cls;
    logic signed [DW-1:0] score;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_ready = 1'b0;
  logic res_ready = 1'b0;
  logic signed [DW-1:0] d [4][2];
  logic r [4][2];
  logic res_valid, res_class, busy, done;
  logic [1:0] res_node;
  logic signed [DW-1:0] res_score;

  rec_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic stall_hold = 1'b0;
  rec_t held;

  always #5 clk = ~clk;

  gnn_out_collector dut (
    .clk(clk), .rst(rst), .in_ready(in_ready),
    .out0_node0(d[0][0]), .out1_node0(d[0][1]),
    .out0_node1(d[1][0]), .out1_node1(d[1][1]),
    .out0_node2(d[2][0]), .out1_node2(d[2][1]),
    .out0_node3(d[3][0]), .out1_node3(d[3][1]),
    .out10_ready_node0(r[0][0]), .out11_ready_node0(r[0][1]),
    .out10_ready_node1(r[1][0]), .out11_ready_node1(r[1][1]),
    .out10_ready_node2(r[2][0]), .out11_ready_node2(r[2][1]),
    .out10_ready_node3(r[3][0]), .out11_ready_node3(r[3][1]),
    .res_valid(res_valid), .res_ready(res_ready), .res_node(res_node),
    .res_class(res_class), .res_score(res_score), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_all();
    rec_t e;
    for (int n = 0; n < 4; n++) begin
      e.node  = 2'(n);
      e.cls   = (d[n][1] > d[n][0]);
      e.score = e.cls ? d[n][1] : d[n][0];
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("valid_seen", res_valid, 1);
  endtask

  task automatic wait_done(input int exp);
    int c = 0;
    while (done_cnt < exp && c < 100) begin
      tick();
      c++;
    end
    tick();
    chk("done_cnt", done_cnt, exp);
    chk("sb_empty", sb.size(), 0);
    chk("idle_busy", busy, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_hold && res_valid) begin
        chk("hold_node", res_node, held.node);
        chk("hold_class", res_class, held.cls);
        chk("hold_score", res_score, held.score);
      end
      if (res_valid && res_ready) begin
        if (sb.size() > 0) begin
          rec_t e;
          e = sb.pop_front();
          chk("rec_node", res_node, e.node);
          chk("rec_class", res_class, e.cls);
          chk("rec_score", res_score, e.score);
        end else begin
          chk("sb_underflow", sb.size(), 1);
        end
      end
      stall_hold = res_valid && !res_ready;
      held.node  = res_node;
      held.cls   = res_class;
      held.score = res_score;
      if (done) begin
        done_cnt++;
        chk("done_valid", res_valid, 0);
      end
    end else begin
      stall_hold = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int cnt;
    int sched [4][2] = '{'{0, 2}, '{1, 3}, '{4, 5}, '{5, 0}};
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 2; k++) begin
        d[n][k] = '0;
        r[n][k] = 1'b0;
      end

    // Reset state
    repeat (2) tick();
    chk("rst_valid", res_valid, 0);
    chk("rst_node", res_node, 0);
    chk("rst_class", res_class, 0);
    chk("rst_score", res_score, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // T1: all readies high before start, back-to-back records
    d[0][0] = 5;        d[0][1] = 9;
    d[1][0] = 100;      d[1][1] = -7;
    d[2][0] = -3;       d[2][1] = -3;
    d[3][0] = -1048576; d[3][1] = 1;
    for (int n = 0; n < 4; n++) begin
      r[n][0] = 1'b1;
      r[n][1] = 1'b1;
    end
    push_all();
    res_ready = 1'b1;
    start();
    chk("t1_busy", busy, 1);
    wait_valid(cyc);
    chk("t1_latency", cyc, 3);
    chk("t1_first_node", res_node, 0);
    chk("t1_first_class", res_class, 1);
    chk("t1_first_score", res_score, 9);
    cnt = 0;
    while (!done && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("t1_emit_cycles", cnt, 4);
    wait_done(1);

    // T2: staggered readies, data corrupted after capture, mid-capture restart, stall on node1
    for (int n = 0; n < 4; n++) begin
      r[n][0] = 1'b0;
      r[n][1] = 1'b0;
    end
    d[0][0] = 7;   d[0][1] = -2;
    d[1][0] = -50; d[1][1] = -50;
    d[2][0] = 300; d[2][1] = 301;
    d[3][0] = 0;   d[3][1] = -1;
    push_all();
    res_ready = 1'b0;
    start();
    for (int c = 0; c < 6; c++) begin
      for (int n = 0; n < 4; n++)
        for (int k = 0; k < 2; k++)
          if (sched[n][k] == c) r[n][k] = 1'b1;
      if (c == 3) in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      for (int n = 0; n < 4; n++)
        for (int k = 0; k < 2; k++)
          if (sched[n][k] <= c) d[n][k] = d[n][k] + 21'sd1000 + DW'(c);
    end
    wait_valid(cyc);
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    repeat (3) tick();
    chk("stall_valid", res_valid, 1);
    chk("stall_node", res_node, 1);
    res_ready = 1'b1;
    wait_done(2);

    // T3: reset during EMIT after node1 accepted
    for (int n = 0; n < 4; n++) begin
      d[n][0] = DW'(-11 * n);
      d[n][1] = DW'(4 * n - 5);
    end
    push_all();
    start();
    wait_valid(cyc);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_valid", res_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_node", res_node, 0);
    chk("abort_score", res_score, 0);
    chk("abort_done", done, 0);
    chk("abort_sb", sb.size(), 2);
    sb.delete();
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("abort_no_done", done_cnt, 2);
    chk("abort_idle", res_valid, 0);

    // T4: fresh inference after the abort
    d[0][0] = 12;  d[0][1] = 13;
    d[1][0] = -1;  d[1][1] = -2;
    d[2][0] = 1048575; d[2][1] = -1048576;
    d[3][0] = -9;  d[3][1] = 8;
    push_all();
    start();
    wait_valid(cyc);
    chk("t4_latency", cyc, 3);
    wait_done(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
